// File: rtl/frame_sample_gen.sv
// RFID frame serializer: preamble, MSB-first data field, inverted CRC-16, as NRZ or FM0 samples.
// Defining FRAME_GEN_DUMMY_EN appends one dummy '1' bit after the CRC.
module frame_sample_gen #(
   parameter int                 MAX_BITS = 128,
   parameter int                 SPB      = 8,
   parameter int                 PRE_LEN  = 12,
   parameter logic [PRE_LEN-1:0] PREAMBLE = 12'b110100100011,
   parameter int                 LEN_W    = $clog2(MAX_BITS+1)
) (
   input  logic                sys_clk,
   input  logic                rst,
   input  logic                samp_en,
   input  logic                start,
   input  logic                mode,
   input  logic [MAX_BITS-1:0] data_in,
   input  logic [LEN_W-1:0]    data_len,
   output logic                busy,
   output logic                done,
   output logic                samp_out,
   output logic                samp_valid,
   output logic [15:0]         crc_out
);

   localparam int SC_W    = (SPB > 2) ? $clog2(SPB) : 1;
   localparam int CNT_MAX = (MAX_BITS > PRE_LEN) ? ((MAX_BITS > 16) ? MAX_BITS : 16)
                                                 : ((PRE_LEN > 16) ? PRE_LEN : 16);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      DATA,
      CRC,
`ifdef FRAME_GEN_DUMMY_EN
      DUMMY,
`endif
      FIN
   } state_t;

   state_t              state;
   logic [SC_W-1:0]     samp_cnt;
   logic [CNT_W-1:0]    bit_cnt;
   logic                mode_r;
   logic [LEN_W-1:0]    len_r;
   logic [PRE_LEN-1:0]  pre_sh;
   logic [MAX_BITS-1:0] data_sh;
   logic [15:0]         crc_sh;
   logic [15:0]         crc_reg;

   logic [LEN_W-1:0]    len_cl;
   logic                cur_bit;
   logic                level;
   logic                last_bit;
   logic                bit_end;

   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
      logic [15:0] sh;
      sh = {crc[14:0], 1'b0};
      if (crc[15] ^ b) begin
         crc16_step = sh ^ 16'h1021;
      end else begin
         crc16_step = sh;
      end
   endfunction

   // Clamp length, select the bit on air and derive the next sample level
   always_comb begin
      len_cl   = (data_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : data_len;
      cur_bit  = 1'b0;
      last_bit = 1'b0;
      bit_end  = (samp_cnt == SC_W'(SPB - 1));
      case (state)
         PRE: begin
            cur_bit  = pre_sh[PRE_LEN-1];
            last_bit = (bit_cnt == CNT_W'(PRE_LEN - 1));
         end
         DATA: begin
            cur_bit  = data_sh[MAX_BITS-1];
            last_bit = (bit_cnt == (CNT_W'(len_r) - CNT_W'(1)));
         end
         CRC: begin
            cur_bit  = crc_sh[15];
            last_bit = (bit_cnt == CNT_W'(15));
         end
`ifdef FRAME_GEN_DUMMY_EN
         DUMMY: begin
            cur_bit  = 1'b1;
            last_bit = 1'b1;
         end
`endif
         default: begin
            cur_bit  = 1'b0;
            last_bit = 1'b0;
         end
      endcase
      // FM0 keeps the preamble as plain levels so the data start can invert off it
      if (!mode_r || state == PRE) begin
         level = cur_bit;
      end else if (samp_cnt == SC_W'(0)) begin
         level = ~samp_out;
      end else if (samp_cnt == SC_W'(SPB / 2) && !cur_bit) begin
         level = ~samp_out;
      end else begin
         level = samp_out;
      end
   end

   // Frame sequencer: start acceptance, per-strobe sample generation and bit/state stepping
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         samp_cnt   <= '0;
         bit_cnt    <= '0;
         mode_r     <= 1'b0;
         len_r      <= '0;
         pre_sh     <= '0;
         data_sh    <= '0;
         crc_sh     <= 16'h0000;
         crc_reg    <= 16'hFFFF;
         busy       <= 1'b0;
         done       <= 1'b0;
         samp_out   <= 1'b0;
         samp_valid <= 1'b0;
         crc_out    <= 16'h0000;
      end else begin
         done       <= 1'b0;
         samp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= PRE;
                  busy     <= 1'b1;
                  mode_r   <= mode;
                  len_r    <= len_cl;
                  pre_sh   <= PREAMBLE;
                  data_sh  <= data_in << (LEN_W'(MAX_BITS) - len_cl);
                  crc_reg  <= 16'hFFFF;
                  crc_out  <= 16'h0000;
                  samp_cnt <= '0;
                  bit_cnt  <= '0;
               end
            end
            FIN: begin
               if (samp_en) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  samp_out <= 1'b0;
               end
            end
            default: begin
               if (samp_en) begin
                  samp_valid <= 1'b1;
                  samp_out   <= level;
                  if (state == DATA && samp_cnt == SC_W'(0)) begin
                     crc_reg <= crc16_step(crc_reg, cur_bit);
                  end
                  if (bit_end) begin
                     samp_cnt <= '0;
                     bit_cnt  <= last_bit ? CNT_W'(0) : bit_cnt + CNT_W'(1);
                     case (state)
                        PRE: begin
                           pre_sh <= {pre_sh[PRE_LEN-2:0], 1'b0};
                           if (last_bit) begin
                              if (len_r == LEN_W'(0)) begin
                                 state   <= CRC;
                                 crc_out <= ~crc_reg;
                                 crc_sh  <= ~crc_reg;
                              end else begin
                                 state <= DATA;
                              end
                           end
                        end
                        DATA: begin
                           data_sh <= {data_sh[MAX_BITS-2:0], 1'b0};
                           if (last_bit) begin
                              state   <= CRC;
                              crc_out <= ~crc_reg;
                              crc_sh  <= ~crc_reg;
                           end
                        end
                        CRC: begin
                           crc_sh <= {crc_sh[14:0], 1'b0};
                           if (last_bit) begin
`ifdef FRAME_GEN_DUMMY_EN
                              state <= DUMMY;
`else
                              state <= FIN;
`endif
                           end
                        end
                        default: begin
                           state <= FIN;
                        end
                     endcase
                  end else begin
                     samp_cnt <= samp_cnt + SC_W'(1);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_sample_gen.sv
// Scoreboard bench for frame_sample_gen: expected samples are queued per frame and compared on samp_valid.
module tb_frame_sample_gen;

   localparam int MAXB    = 128;
   localparam int SPB     = 8;
   localparam int PRE_LEN = 12;
   localparam int LEN_W   = 8;

   logic             sys_clk = 1'b0;
   logic             rst = 1'b1;
   logic             samp_en = 1'b0;
   logic             start = 1'b0;
   logic             mode = 1'b0;
   logic [MAXB-1:0]  data_in = '0;
   logic [LEN_W-1:0] data_len = '0;
   logic             busy, done, samp_out, samp_valid;
   logic [15:0]      crc_out;

   logic exp_q[$];
   int   n_checks = 0;
   int   n_err = 0;
   int   nsamp = 0;
   int   done_cnt = 0;
   bit   sb_on = 1'b0;

   frame_sample_gen #(.MAX_BITS(MAXB), .SPB(SPB), .PRE_LEN(PRE_LEN)) dut (
      .sys_clk(sys_clk), .rst(rst), .samp_en(samp_en), .start(start), .mode(mode),
      .data_in(data_in), .data_len(data_len), .busy(busy), .done(done),
      .samp_out(samp_out), .samp_valid(samp_valid), .crc_out(crc_out)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Monitor: compare every emitted sample against the scoreboard
   always @(negedge sys_clk) begin
      if (!rst && samp_valid) begin
         nsamp <= nsamp + 1;
         if (sb_on) begin
            if (exp_q.size() == 0) check_eq("extra_sample", 32'd1, 32'd0);
            else check_eq("sample", {31'd0, samp_out}, {31'd0, exp_q.pop_front()});
         end
      end
      if (!rst && done) done_cnt <= done_cnt + 1;
   end

   task automatic build_expected(input logic m, input logic [127:0] d, input int len,
                                 output logic [15:0] crc);
      logic bits[$];
      logic [11:0] pre;
      int   l;
      logic lev;
      logic fb;
      pre = 12'b110100100011;
      l = (len > MAXB) ? MAXB : len;
      crc = 16'hFFFF;
      for (int i = PRE_LEN - 1; i >= 0; i--) bits.push_back(pre[i]);
      for (int i = l - 1; i >= 0; i--) begin
         bits.push_back(d[i]);
         fb  = crc[15] ^ d[i];
         crc = {crc[14:0], 1'b0};
         if (fb) crc = crc ^ 16'h1021;
      end
      crc = ~crc;
      for (int i = 15; i >= 0; i--) bits.push_back(crc[i]);
`ifdef FRAME_GEN_DUMMY_EN
      bits.push_back(1'b1);
`endif
      lev = 1'b0;
      for (int j = 0; j < bits.size(); j++) begin
         for (int k = 0; k < SPB; k++) begin
            if (j < PRE_LEN || !m) lev = bits[j];
            else if (k == 0) lev = ~lev;
            else if (k == SPB / 2 && !bits[j]) lev = ~lev;
            exp_q.push_back(lev);
         end
      end
   endtask

   task automatic run_frame(input logic m, input logic [127:0] d, input int len,
                            input int pause_at, input bit poke);
      logic [15:0] ecrc;
      logic held;
      bit   got_done;
      bit   paused;
      int   base;
      build_expected(m, d, len, ecrc);
      sb_on = 1'b1;
      @(posedge sys_clk); #1;
      base = nsamp;
      start = 1'b1; mode = m; data_in = d; data_len = len[LEN_W-1:0]; samp_en = 1'b1;
      @(posedge sys_clk); #1;
      start = 1'b0; data_in = ~d; data_len = 8'd3; mode = ~m;
      check_eq("busy_on", {31'd0, busy}, 32'd1);
      got_done = 1'b0;
      paused = 1'b0;
      for (int cyc = 0; cyc < 6000 && !got_done; cyc++) begin
         if (pause_at >= 0 && !paused && (nsamp - base) == pause_at) begin
            paused = 1'b1;
            samp_en = 1'b0;
            held = samp_out;
            repeat (50) begin
               @(posedge sys_clk); #1;
               check_eq("pause_valid", {31'd0, samp_valid}, 32'd0);
               check_eq("pause_hold", {31'd0, samp_out}, {31'd0, held});
            end
            samp_en = 1'b1;
         end
         start = (poke && cyc == 30) ? 1'b1 : 1'b0;
         @(posedge sys_clk); #1;
         if (done) got_done = 1'b1;
      end
      start = 1'b0;
      check_eq("done_seen", {31'd0, got_done}, 32'd1);
      check_eq("end_busy", {31'd0, busy}, 32'd0);
      check_eq("end_samp", {31'd0, samp_out}, 32'd0);
      check_eq("samples_left", exp_q.size(), 32'd0);
      check_eq("crc_out", {16'd0, crc_out}, {16'd0, ecrc});
      @(posedge sys_clk); #1;
      check_eq("done_pulse", {31'd0, done}, 32'd0);
      exp_q.delete();
   endtask

   initial begin
      int d0;
      repeat (3) @(posedge sys_clk);
      #1 rst = 1'b0;
      @(posedge sys_clk); #1;
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_samp", {31'd0, samp_out}, 32'd0);
      check_eq("rst_valid", {31'd0, samp_valid}, 32'd0);
      check_eq("rst_crc", {16'd0, crc_out}, 32'd0);

      // Reset in the middle of the data field
      sb_on = 1'b0;
      start = 1'b1; mode = 1'b0; data_in = 128'hA5A5_F00F; data_len = 8'd32; samp_en = 1'b1;
      @(posedge sys_clk); #1;
      start = 1'b0;
      repeat (150) @(posedge sys_clk);
      #1;
      d0 = done_cnt;
      rst = 1'b1;
      #2;
      check_eq("abort_busy", {31'd0, busy}, 32'd0);
      check_eq("abort_samp", {31'd0, samp_out}, 32'd0);
      repeat (3) @(posedge sys_clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      check_eq("abort_nodone", done_cnt, d0);

      run_frame(1'b0, 128'h5A, 8, -1, 1'b0);
      run_frame(1'b0, 128'h0, 0, -1, 1'b0);
      check_eq("crc_len0", {16'd0, crc_out}, 32'h0000);
      run_frame(1'b0, 128'h313233343536373839, 72, -1, 1'b0);
      check_eq("crc_spec", {16'd0, crc_out}, 32'hD64E);
      run_frame(1'b1, 128'h1, 2, -1, 1'b0);
      run_frame(1'b0, {$urandom, $urandom, $urandom, $urandom}, 200, -1, 1'b1);
      run_frame(1'b1, 128'h313233343536373839, 72, (PRE_LEN + 72) * SPB + 40, 1'b0);
      run_frame(1'b1, 128'h0, 0, -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
